window_control: RTL and testbench

WINDOW_CONTROL -- requirements
Module: window_control

---
 rtl/window_control_pkg.sv | 23 ++
 rtl/window_control_line_store.sv | 40 ++++
 rtl/window_control.sv | 106 ++++++++++
 tb/tb_window_control.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_control_pkg.sv
// Shared definitions for the 3x3 raster window generator: default geometry,
// FSM encoding and the line-storage occupancy thresholds.
package window_control_pkg;

    localparam int DEF_WIDTH = 640;
    localparam int DEF_PIX_W = 8;
    localparam int FILL_W    = 12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Occupancy at which three complete rows are available for a window line.
    function automatic logic [FILL_W-1:0] read_level(input int width);
        return FILL_W'(3 * width);
    endfunction

    function automatic logic [FILL_W-1:0] full_level(input int width);
        return FILL_W'(4 * width);
    endfunction

endpackage

// File: rtl/window_control_line_store.sv
// One image line of pixel storage with a single write port and a
// three-tap read {col-1, col, col+1} zero-padded at both line ends.
module line_store
    import window_control_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(WIDTH)-1:0]   wr_col,
    input  logic [PIX_W-1:0]           wr_data,
    input  logic [$clog2(WIDTH)-1:0]   rd_col,
    output logic [3*PIX_W-1:0]         taps
);

    localparam int COL_W = $clog2(WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

    logic [PIX_W-1:0] mem [WIDTH];
    logic [COL_W-1:0] left_col;
    logic [COL_W-1:0] right_col;

    // Pixel storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    // Neighbour taps; edge columns are clamped for addressing, then masked to zero.
    always_comb begin
        left_col  = (rd_col == COL_W'(0)) ? rd_col : rd_col - COL_W'(1);
        right_col = (rd_col == LAST_COL)  ? rd_col : rd_col + COL_W'(1);
        taps = {(rd_col == COL_W'(0)) ? PIX_W'(0) : mem[left_col],
                mem[rd_col],
                (rd_col == LAST_COL)  ? PIX_W'(0) : mem[right_col]};
    end

endmodule

// File: rtl/window_control.sv
// 3x3 sliding-window generator over a raster pixel stream, built on four
// rotating line stores; emits one registered window per read step.
module window_control
    import window_control_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_valid,
    output logic [9*PIX_W-1:0] win_data,
    output logic               win_valid,
    output logic               line_done,
    output logic               ovf
);

    localparam int COL_W = $clog2(WIDTH);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] READ_LEVEL = read_level(WIDTH);
    localparam logic [FILL_W-1:0] FULL_LEVEL = full_level(WIDTH);

    state_t             state;
    logic [1:0]         wr_sel;
    logic [1:0]         rd_sel;
    logic [COL_W-1:0]   wr_col;
    logic [COL_W-1:0]   rd_col;
    logic [FILL_W-1:0]  fill;
    logic               wr_acc;
    logic               rd_step;
    logic               last_step;
    logic [3:0]         wr_en;
    logic [3*PIX_W-1:0] taps [4];
    logic [9*PIX_W-1:0] window;

    // Write admission, read-step qualification and rotating row selection.
    always_comb begin
        wr_acc    = pix_valid && (fill != FULL_LEVEL);
        rd_step   = (state == READ);
        last_step = rd_step && (rd_col == LAST_COL);
        wr_en     = 4'b0000;
        wr_en[wr_sel] = wr_acc;
        window    = {taps[rd_sel], taps[rd_sel + 2'd1], taps[rd_sel + 2'd2]};
    end

    for (genvar i = 0; i < 4; i++) begin : g_line
        line_store #(
            .WIDTH (WIDTH),
            .PIX_W (PIX_W)
        ) u_line (
            .clk     (clk),
            .wr_en   (wr_en[i]),
            .wr_col  (wr_col),
            .wr_data (pix_data),
            .rd_col  (rd_col),
            .taps    (taps[i])
        );
    end

    // Pointers, occupancy, FSM and the registered window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_sel    <= 2'd0;
            wr_col    <= COL_W'(0);
            rd_sel    <= 2'd0;
            rd_col    <= COL_W'(0);
            fill      <= FILL_W'(0);
            win_data  <= '0;
            win_valid <= 1'b0;
            line_done <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (wr_col == LAST_COL) begin
                    wr_col <= COL_W'(0);
                    wr_sel <= wr_sel + 2'd1;
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end
            if (pix_valid && !wr_acc) begin
                ovf <= 1'b1;
            end
            fill <= fill + FILL_W'(wr_acc) - FILL_W'(rd_step);
            case (state)
                IDLE:    if (fill >= READ_LEVEL) state <= READ;
                READ:    if (last_step) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (rd_step) begin
                win_data <= window;
                if (last_step) begin
                    rd_col <= COL_W'(0);
                    rd_sel <= rd_sel + 2'd1;
                end else begin
                    rd_col <= rd_col + COL_W'(1);
                end
            end
            win_valid <= rd_step;
            line_done <= last_step;
        end
    end

endmodule

// File: tb/tb_window_control.sv
// Directed bench for window_control: a WIDTH=4 instance for the hand-computed
// cases and a WIDTH=640 instance for a random multi-line image.
module tb_window_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_pix = 8'd0;
    logic        s_pv  = 1'b0;
    logic [71:0] s_win;
    logic        s_wv, s_ld, s_ovf;
    logic [7:0]  b_pix = 8'd0;
    logic        b_pv  = 1'b0;
    logic [71:0] b_win;
    logic        b_wv, b_ld, b_ovf;

    int n_vec = 0;
    int n_err = 0;

    // Accepted-pixel images: small DUT at base 0, big DUT at base 4096.
    logic [7:0]  img [0:8191];
    int          s_n, s_line, s_col, s_nwin, s_done;
    int          b_n, b_line, b_col, b_nwin, b_done;
    logic [71:0] s_last, b_last;
    logic        s_prev, b_prev;

    window_control #(.WIDTH(4), .PIX_W(8)) u_small (
        .clk(clk), .rst(rst), .pix_data(s_pix), .pix_valid(s_pv),
        .win_data(s_win), .win_valid(s_wv), .line_done(s_ld), .ovf(s_ovf)
    );

    window_control #(.WIDTH(640), .PIX_W(8)) u_big (
        .clk(clk), .rst(rst), .pix_data(b_pix), .pix_valid(b_pv),
        .win_data(b_win), .win_valid(b_wv), .line_done(b_ld), .ovf(b_ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int base, input int w, input int line, input int col);
        logic [71:0] r;
        logic [7:0]  p;
        int          c;
        r = 72'd0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                c = col + cc - 1;
                p = (c < 0 || c >= w) ? 8'd0 : img[base + (line + rr) * w + c];
                r = {r[63:0], p};
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        s_n = 0; s_line = 0; s_col = 0; s_nwin = 0; s_done = 0; s_last = 72'd0; s_prev = 1'b0;
        b_n = 0; b_line = 0; b_col = 0; b_nwin = 0; b_done = 0; b_last = 72'd0; b_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_pv = 1'b0; b_pv = 1'b0;
        clear_model();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic s_push(input logic [7:0] v, input logic keep);
        s_pv = 1'b1; s_pix = v;
        if (keep) begin img[s_n] = v; s_n++; end
        tick();
    endtask

    task automatic b_push(input logic [7:0] v);
        b_pv = 1'b1; b_pix = v;
        img[4096 + b_n] = v; b_n++;
        tick();
    endtask

    task automatic wait_small_win(input string tag);
        int k;
        k = 0;
        while (s_wv !== 1'b1 && k < 20) begin tick(); k++; end
        check(tag, 72'(s_wv), 72'd1);
    endtask

    task automatic wait_big_lines(input int target, input int budget);
        int k;
        k = 0;
        while (b_done < target && k < budget) begin tick(); k++; end
        tick(); tick(); tick();
        check("b_lines", 72'(b_done), 72'(target));
    endtask

    // Small-instance scoreboard: every window, hold, line_done and bubble.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("s_fill_max", 72'(u_small.fill <= 12'd16), 72'd1);
            if (s_prev) check("s_bubble", 72'(s_wv), 72'd0);
            if (s_wv) begin
                check("s_win", s_win, exp_win(0, 4, s_line, s_col));
                check("s_done_at_end", 72'(s_ld), 72'(s_col == 3));
                s_last = s_win; s_nwin++;
                if (s_col == 3) begin s_col = 0; s_line++; s_done++; end
                else s_col++;
            end else begin
                check("s_hold", s_win, s_last);
                check("s_done_idle", 72'(s_ld), 72'd0);
            end
            s_prev = s_ld;
        end
    end

    // Big-instance scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (b_prev) check("b_bubble", 72'(b_wv), 72'd0);
            if (b_wv) begin
                check("b_win", b_win, exp_win(4096, 640, b_line, b_col));
                check("b_done_at_end", 72'(b_ld), 72'(b_col == 639));
                b_last = b_win; b_nwin++;
                if (b_col == 639) begin b_col = 0; b_line++; b_done++; end
                else b_col++;
            end else begin
                check("b_hold", b_win, b_last);
                check("b_done_idle", 72'(b_ld), 72'd0);
            end
            b_prev = b_ld;
        end
    end

    initial begin
        // Reset state and first line from pixels 1..12.
        do_reset();
        check("rst_valid", 72'(s_wv), 72'd0);
        check("rst_done", 72'(s_ld), 72'd0);
        check("rst_ovf", 72'(s_ovf), 72'd0);
        check("rst_data", s_win, 72'd0);
        for (int k = 1; k <= 12; k++) begin
            check("a_no_early", 72'(s_wv), 72'd0);
            s_push(8'(k), 1'b1);
        end
        s_pv = 1'b0;
        check("a_no_early", 72'(s_wv), 72'd0);
        wait_small_win("a_first_valid");
        check("a_first_win", s_win, {8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6, 8'd0, 8'd9, 8'd10});
        check("a_first_done", 72'(s_ld), 72'd0);
        tick(); tick(); tick();
        check("a_last_win", s_win, {8'd3, 8'd4, 8'd0, 8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0});
        check("a_last_done", 72'(s_ld), 72'd1);
        tick();
        check("a_bubble", 72'(s_wv), 72'd0);

        // Second line uses rows 2..4.
        for (int k = 13; k <= 16; k++) s_push(8'(k), 1'b1);
        s_pv = 1'b0;
        wait_small_win("b_first_valid");
        check("b_first_win", s_win, {8'd0, 8'd5, 8'd6, 8'd0, 8'd9, 8'd10, 8'd0, 8'd13, 8'd14});
        tick(); tick(); tick();
        check("b_last_done", 72'(s_ld), 72'd1);
        tick();
        check("b_lines", 72'(s_done), 72'd2);

        // Continuous 40 pixels: storage saturates, pixels 29, 34, 39 are dropped.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (k == 28) check("c_ovf_before", 72'(s_ovf), 72'd0);
            s_push(8'(k + 1), !(k == 28 || k == 33 || k == 38));
        end
        s_pv = 1'b0;
        check("c_ovf_set", 72'(s_ovf), 72'd1);
        repeat (20) tick();
        check("c_lines", 72'(s_done), 72'd7);
        check("c_windows", 72'(s_nwin), 72'd28);
        check("c_ovf_sticky", 72'(s_ovf), 72'd1);

        // Reset on the second window of a line, then a fresh frame.
        do_reset();
        for (int k = 101; k <= 112; k++) s_push(8'(k), 1'b1);
        s_pv = 1'b0;
        wait_small_win("d_first_valid");
        check("d_first_win", s_win, {8'd0, 8'd101, 8'd102, 8'd0, 8'd105, 8'd106, 8'd0, 8'd109, 8'd110});
        tick();
        check("d_second_valid", 72'(s_wv), 72'd1);
        rst = 1'b1;
        clear_model();
        tick();
        check("d_rst_valid", 72'(s_wv), 72'd0);
        check("d_rst_done", 72'(s_ld), 72'd0);
        check("d_rst_ovf", 72'(s_ovf), 72'd0);
        check("d_rst_data", s_win, 72'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("d_no_done", 72'(s_ld), 72'd0);
            check("d_no_valid", 72'(s_wv), 72'd0);
        end
        for (int k = 201; k <= 212; k++) s_push(8'(k), 1'b1);
        s_pv = 1'b0;
        wait_small_win("d_fresh_valid");
        check("d_fresh_win", s_win, {8'd0, 8'd201, 8'd202, 8'd0, 8'd205, 8'd206, 8'd0, 8'd209, 8'd210});
        repeat (6) tick();
        check("d_lines", 72'(s_done), 72'd1);

        // WIDTH=640 random image: 5 lines give 3 output lines, a 6th wraps rd_sel.
        do_reset();
        for (int k = 0; k < 3200; k++) b_push(8'($urandom));
        b_pv = 1'b0;
        wait_big_lines(3, 4000);
        check("b_windows3", 72'(b_nwin), 72'd1920);
        check("b_rd_sel3", 72'(u_big.rd_sel), 72'd3);
        check("b_ovf", 72'(b_ovf), 72'd0);
        for (int k = 0; k < 640; k++) b_push(8'($urandom));
        b_pv = 1'b0;
        wait_big_lines(4, 2000);
        check("b_windows4", 72'(b_nwin), 72'd2560);
        check("b_rd_sel_wrap", 72'(u_big.rd_sel), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
